// File: rtl/bcd_range_counter_pkg.sv
// Shared BCD helpers for the range counters: digit width, int->BCD conversion,
// nibble validity and the parameter range rule used at elaboration.
// Pure constants/functions; no latency, no flow control.
package bcd_cnt_pkg;

    localparam int BCD_DIGIT_W = 4;

    // Two-digit packed BCD {tens, ones} of a decimal value 0..99.
    function automatic logic [2*BCD_DIGIT_W-1:0] to_bcd2(input int v);
        logic [BCD_DIGIT_W-1:0] tens;
        logic [BCD_DIGIT_W-1:0] ones;
        tens = BCD_DIGIT_W'((v / 10) % 10);
        ones = BCD_DIGIT_W'(v % 10);
        return {tens, ones};
    endfunction

    // True when both nibbles are legal decimal digits.
    function automatic logic bcd2_valid(input logic [2*BCD_DIGIT_W-1:0] v);
        return (v[2*BCD_DIGIT_W-1:BCD_DIGIT_W] <= 4'd9) && (v[BCD_DIGIT_W-1:0] <= 4'd9);
    endfunction

    // Legal counter range: 0 <= min < max <= 99.
    function automatic bit range_ok(input int min_v, input int max_v);
        return (min_v >= 0) && (min_v < max_v) && (max_v <= 99);
    endfunction

endpackage

// File: rtl/bcd_range_counter_if.sv
// Control/data bundle between a BCD range counter and whoever drives it.
// Master drives EN/incre/(decre)/load/D; slave returns Q, ENL and load_err.
// decre exists only when BCD_CNT_DECRE_EN is defined.
interface bcd_range_counter_if;

    logic       EN;
    logic       incre;
    logic       load;
    logic [7:0] D;
    logic [7:0] Q;
    logic       ENL;
    logic       load_err;
`ifdef BCD_CNT_DECRE_EN
    logic       decre;

    modport master (output EN, incre, decre, load, D, input Q, ENL, load_err);
    modport slave  (input EN, incre, decre, load, D, output Q, ENL, load_err);
`else
    modport master (output EN, incre, load, D, input Q, ENL, load_err);
    modport slave  (input EN, incre, load, D, output Q, ENL, load_err);
`endif

endinterface

// File: rtl/bcd_range_counter_digit.sv
// Single BCD decade stepper: +1 wraps 9->0 with carry, -1 wraps 0->9 with borrow.
// Purely combinational (zero latency); the caller owns the register.
// No flow control. Ports: d_in, inc, dec in; d_out, carry, borrow out.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_in,
    input  logic                   inc,
    input  logic                   dec,
    output logic [BCD_DIGIT_W-1:0] d_out,
    output logic                   carry,
    output logic                   borrow
);

    always_comb begin
        d_out  = d_in;
        carry  = 1'b0;
        borrow = 1'b0;
        if (inc) begin
            // >= rather than == keeps a corrupted nibble from counting past 9
            if (d_in >= 4'd9) begin
                d_out = '0;
                carry = 1'b1;
            end else begin
                d_out = d_in + 4'd1;
            end
        end else if (dec) begin
            if (d_in == 4'd0) begin
                d_out  = 4'd9;
                borrow = 1'b1;
            end else begin
                d_out = d_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_range_counter.sv
// Two-digit BCD counter over MIN_VAL..MAX_VAL with wrap, cascade enable, manual step, checked load.
// Latency: one CP edge from any strobe to Q; load_err one edge after the strobe; ENL combinational.
// No backpressure: one action per edge (reset > load > incre > decre > EN), lower ones dropped.
// Ports: CP, reset (sync, active-high), bus (slave: EN, incre, [decre], load, D -> Q, ENL, load_err).
// Optional macro BCD_CNT_DECRE_EN adds the decre down-step.
module bcd_range_counter
    import bcd_cnt_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic                 CP,
    input  logic                 reset,
    bcd_range_counter_if.slave   bus
);

    if (!range_ok(MIN_VAL, MAX_VAL)) begin : g_bad_range
        $error("bcd_range_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    localparam logic [7:0] MIN_BCD = to_bcd2(MIN_VAL);
    localparam logic [7:0] MAX_BCD = to_bcd2(MAX_VAL);

    logic [7:0] q;
    logic       load_err;
    logic       up_req;
    logic       dn_req;
    logic       dn_strobe;

`ifdef BCD_CNT_DECRE_EN
    assign dn_strobe = bus.decre;
`else
    assign dn_strobe = 1'b0;
`endif

    // incre beats decre, decre beats EN; load/reset are resolved in the register.
    assign up_req = bus.incre | (~dn_strobe & bus.EN);
    assign dn_req = ~bus.incre & dn_strobe;

    logic [BCD_DIGIT_W-1:0] ones_nxt;
    logic [BCD_DIGIT_W-1:0] tens_nxt;
    logic                   ones_carry;
    logic                   ones_borrow;
    logic                   unused_tens_carry;
    logic                   unused_tens_borrow;

    bcd_digit u_ones (
        .d_in   (q[BCD_DIGIT_W-1:0]),
        .inc    (up_req),
        .dec    (dn_req),
        .d_out  (ones_nxt),
        .carry  (ones_carry),
        .borrow (ones_borrow)
    );

    // Tens only moves when the ones digit wraps; its own wrap is superseded
    // by the range wrap below, so carry/borrow out of tens go nowhere.
    bcd_digit u_tens (
        .d_in   (q[2*BCD_DIGIT_W-1:BCD_DIGIT_W]),
        .inc    (up_req & ones_carry),
        .dec    (dn_req & ones_borrow),
        .d_out  (tens_nxt),
        .carry  (unused_tens_carry),
        .borrow (unused_tens_borrow)
    );

    // Valid BCD orders the same as the decimal it encodes, so plain unsigned
    // compares against the BCD bounds are exact once both nibbles are checked.
    logic load_ok;
    assign load_ok = bcd2_valid(bus.D) && (bus.D >= MIN_BCD) && (bus.D <= MAX_BCD);

    always_ff @(posedge CP) begin
        if (reset) begin
            q        <= MIN_BCD;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (bus.load) begin
                if (load_ok) q        <= bus.D;
                else         load_err <= 1'b1;
            end else if (up_req) begin
                q <= (q == MAX_BCD) ? MIN_BCD : {tens_nxt, ones_nxt};
            end else if (dn_req) begin
                q <= (q == MIN_BCD) ? MAX_BCD : {tens_nxt, ones_nxt};
            end
        end
    end

    assign bus.Q        = q;
    assign bus.load_err = load_err;
    // Carry-out only for an EN-driven wrap, so a downstream stage steps on the same edge.
    assign bus.ENL      = bus.EN & (q == MAX_BCD) & ~reset & ~bus.load & ~bus.incre & ~dn_strobe;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Directed bench for three counter flavours: 00..59, 01..12 and 00..23.
// Expected Q/load_err are queued when stimulus is applied and checked after the edge.
// ENL is combinational and checked directly before each edge.
module tb_bcd_range_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_range_counter_if if59 ();
    bcd_range_counter_if if12 ();
    bcd_range_counter_if if23 ();

    bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(59)) u59 (.CP(clk), .reset(reset), .bus(if59));
    bcd_range_counter #(.MIN_VAL(1), .MAX_VAL(12)) u12 (.CP(clk), .reset(reset), .bus(if12));
    bcd_range_counter #(.MIN_VAL(0), .MAX_VAL(23)) u23 (.CP(clk), .reset(reset), .bus(if23));

    typedef struct {
        string      tag;
        int         id;
        logic [7:0] q;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [7:0] q_of(input int id);
        case (id)
            0:       return if59.Q;
            1:       return if12.Q;
            default: return if23.Q;
        endcase
    endfunction

    function automatic logic err_of(input int id);
        case (id)
            0:       return if59.load_err;
            1:       return if12.load_err;
            default: return if23.load_err;
        endcase
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_next(input string tag, input int id, input logic [7:0] q, input logic err);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.q   = q;
        e.err = err;
        sb.push_back(e);
    endtask

    // Advance one edge, then drain every expectation queued for it.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk8({e.tag, "_q"}, q_of(e.id), e.q);
            chk1({e.tag, "_err"}, err_of(e.id), e.err);
        end
    endtask

    task automatic idle_all();
        if59.EN = 0; if59.incre = 0; if59.load = 0; if59.D = '0;
        if12.EN = 0; if12.incre = 0; if12.load = 0; if12.D = '0;
        if23.EN = 0; if23.incre = 0; if23.load = 0; if23.D = '0;
`ifdef BCD_CNT_DECRE_EN
        if59.decre = 0; if12.decre = 0; if23.decre = 0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        idle_all();

        // Reset state, ENL held low by reset even with EN high
        if59.EN = 1;
        #1;
        chk1("rst_enl59", if59.ENL, 1'b0);
        expect_next("rst59", 0, 8'h00, 1'b0);
        expect_next("rst12", 1, 8'h01, 1'b0);
        expect_next("rst23", 2, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        if59.EN = 0;
        chk1("rst_enl12", if12.ENL, 1'b0);

        // 0..59: full sweep, ENL only at 59, wrap to 00
        if59.EN = 1;
        for (int i = 0; i < 60; i++) begin
            chk1($sformatf("sweep59_enl_%0d", i), if59.ENL, (i == 59));
            expect_next($sformatf("sweep59_%0d", i), 0, bcd((i + 1) % 60), 1'b0);
            tick();
        end
        if59.EN = 0;

        // 1..12: eleven steps to 12, then ENL and wrap to 01
        if12.EN = 1;
        for (int i = 0; i < 11; i++) begin
            chk1($sformatf("hr12_enl_%0d", i), if12.ENL, 1'b0);
            expect_next($sformatf("hr12_%0d", i), 1, bcd(i + 2), 1'b0);
            tick();
        end
        chk1("hr12_enl_top", if12.ENL, 1'b1);
        expect_next("hr12_wrap", 1, 8'h01, 1'b0);
        tick();
        if12.EN = 0;

        // Load below MIN rejected on the 1..12 counter
        if12.load = 1; if12.D = 8'h00;
        expect_next("hr12_ld00", 1, 8'h01, 1'b1);
        tick();
        if12.load = 0;
        expect_next("hr12_errclr", 1, 8'h01, 1'b0);
        tick();

        // 0..23: incre with EN at 23 wraps without carry
        if23.load = 1; if23.D = 8'h23;
        expect_next("h23_ld23", 2, 8'h23, 1'b0);
        tick();
        if23.load = 0;
        if23.incre = 1; if23.EN = 1;
        chk1("h23_incre_enl", if23.ENL, 1'b0);
        expect_next("h23_incre_wrap", 2, 8'h00, 1'b0);
        tick();
        if23.incre = 0; if23.EN = 0;

        // Manual step across the ones boundary: 09 -> 10
        if23.load = 1; if23.D = 8'h09;
        expect_next("h23_ld09", 2, 8'h09, 1'b0);
        tick();
        if23.load = 0; if23.incre = 1;
        expect_next("h23_inc09", 2, 8'h10, 1'b0);
        tick();
        if23.incre = 0;

        // Load checks: non-BCD nibble, above MAX, then valid
        if23.load = 1; if23.D = 8'h3A;
        expect_next("h23_ld3A", 2, 8'h10, 1'b1);
        tick();
        if23.load = 0;
        expect_next("h23_err_clr", 2, 8'h10, 1'b0);
        tick();
        if23.load = 1; if23.D = 8'h24;
        expect_next("h23_ld24", 2, 8'h10, 1'b1);
        tick();
        if23.D = 8'h17;
        expect_next("h23_ld17", 2, 8'h17, 1'b0);
        tick();

        // Load beats EN; ENL stays low while loading even at MAX
        if23.load = 1; if23.D = 8'h23;
        expect_next("h23_ld23b", 2, 8'h23, 1'b0);
        tick();
        if23.EN = 1; if23.D = 8'h05;
        chk1("h23_load_enl", if23.ENL, 1'b0);
        expect_next("h23_ld_over_en", 2, 8'h05, 1'b0);
        tick();
        if23.load = 0; if23.EN = 0;

`ifdef BCD_CNT_DECRE_EN
        // Down-step: 00 -> 59, 10 -> 09, decre beats EN at MAX
        if59.load = 1; if59.D = 8'h00;
        expect_next("dec_ld00", 0, 8'h00, 1'b0);
        tick();
        if59.load = 0; if59.decre = 1;
        expect_next("dec_wrap", 0, 8'h59, 1'b0);
        tick();
        if59.decre = 0; if59.load = 1; if59.D = 8'h10;
        expect_next("dec_ld10", 0, 8'h10, 1'b0);
        tick();
        if59.load = 0; if59.decre = 1;
        expect_next("dec_10", 0, 8'h09, 1'b0);
        tick();
        if59.decre = 0; if59.load = 1; if59.D = 8'h59;
        expect_next("dec_ld59", 0, 8'h59, 1'b0);
        tick();
        if59.load = 0; if59.decre = 1; if59.EN = 1;
        chk1("dec_enl", if59.ENL, 1'b0);
        expect_next("dec_over_en", 0, 8'h58, 1'b0);
        tick();
        if59.decre = 0; if59.EN = 0;
`endif

        // Mid-operation reset overrides EN and a bad load
        if59.load = 1; if59.D = 8'h45;
        expect_next("mid_ld45", 0, 8'h45, 1'b0);
        tick();
        if59.load = 0; if59.EN = 1;
        if23.load = 1; if23.D = 8'h3A;
        reset = 1'b1;
        #1;
        chk1("mid_rst_enl", if59.ENL, 1'b0);
        expect_next("mid_rst59", 0, 8'h00, 1'b0);
        expect_next("mid_rst12", 1, 8'h01, 1'b0);
        expect_next("mid_rst23", 2, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        if23.load = 0;
        expect_next("post_rst_step", 0, 8'h01, 1'b0);
        tick();
        if59.EN = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_range_counter.md
# bcd_range_counter

Parametrised two-digit BCD counter that counts over an inclusive range MIN_VAL..MAX_VAL and wraps, for hour, minute and second fields of the clock. It also covers 12-hour (1..12) fields, which a zero-based modulus counter cannot express. The block supports cascade enable, manual up-stepping for time setting, parallel load with range checking, and an optional manual down-step. Instances chain through EN/ENL: seconds → minutes → hours.

## Interface
- MIN_VAL, 0, lowest count value (decimal 0..98)
- MAX_VAL, 59, highest count value (decimal MIN_VAL+1..99)
- CP  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; count ← MIN_VAL
- EN  input  1  cascade count enable (carry-in from lower stage)
- incre  input  1  manual step up (time setting), ignores EN
- decre  input  1  manual step down; present only with BCD_CNT_DECRE_EN
- load  input  1  parallel load strobe
- D  input  8  load value, {tens BCD, ones BCD}
- Q  output  8  current count, {tens BCD, ones BCD}
- ENL  output  1  carry-out to next stage
- load_err  output  1  registered one-cycle flag: rejected load

## Operation
- Priority per edge: reset > load > incre > decre > EN. One action per cycle; lower-priority inputs are dropped, not queued.
- reset: Q ← BCD(MIN_VAL), load_err ← 0.
- load: if both nibbles ≤ 9 and MIN_VAL ≤ value ≤ MAX_VAL, then Q ← D and load_err ← 0. Otherwise Q holds and load_err ← 1 for one cycle.
- incre: Q ← Q+1, or MIN_VAL if Q = MAX_VAL. No carry is generated; setting hours never advances the next stage.
- decre: Q ← Q−1, or MAX_VAL if Q = MIN_VAL. No borrow output.
- EN alone: Q ← Q+1, or MIN_VAL if Q = MAX_VAL.
- ENL is combinational: ENL = EN & (Q == MAX_VAL) & ~reset & ~load & ~incre & ~decre. It is high exactly in the cycle whose edge wraps the counter through EN, so a downstream stage steps on the same edge.
- Arithmetic is per-digit BCD:
  - ones 9 → 0 with tens +1;
  - decrement ones 0 → 9 with tens −1;
  - wrap compares the full 8-bit BCD value, never the binary value.
- Q is never outside MIN_VAL..MAX_VAL, and never holds a non-BCD nibble, in any reachable state.
- load_err clears on the next edge without a rejected load.

## Timing
- Reset values: Q = BCD(MIN_VAL), load_err = 0, ENL = 0.
- Latency from load/incre/decre/EN to Q change: one edge. load_err is valid the cycle after the strobe.
- ENL path: Q register → compare → AND gate, zero latency. A chain of N stages must close timing in one CP period.
- Mid-operation reset overrides all inputs on that edge. No state is carried over.

## Configuration
- Macro BCD_CNT_DECRE_EN.
- Defined: decre port exists with behaviour as above.
- Undefined: decre port absent; down-step logic is not synthesised; priority becomes reset > load > incre > EN.

## Structure
- Shared package bcd_cnt_pkg holds:
  - BCD digit width constant (4);
  - function to_bcd2(int) → 8-bit;
  - function bcd2_valid(8-bit) → nibbles ≤ 9;
  - elaboration-time check MIN_VAL < MAX_VAL ≤ 99.
- One sub-module, bcd_digit: a single decade with inc/dec, wrap-to-0/9, and carry/borrow outputs. It is instantiated twice. Range wrap and load checking stay in the top level.

## Test plan
- MIN=0, MAX=59, reset, EN high for 60 cycles → Q steps 00..59. ENL high only in the Q=59 cycle. The next Q is 00.
- MIN=1, MAX=12, reset → Q=01. EN ×11 → Q=12, ENL=1. One more edge → Q=01.
- MIN=0, MAX=23, Q=23, incre and EN both high → Q=00, ENL=0.
- Load cases:
  - load D=8'h3A → Q unchanged, load_err=1 for one cycle;
  - load D=8'h24 with MAX=23 → rejected;
  - load D=8'h17 → Q=17, load_err=0.
- With BCD_CNT_DECRE_EN, MIN=0, MAX=59, Q=00, decre → Q=59. Then Q=10, decre → Q=09.
- Q=45, EN high, assert reset → Q=BCD(MIN_VAL) next edge, ENL=0, load_err=0.
